// File: rtl/falafel_stream_fifo.sv
// First-word-fall-through stream FIFO: registered head stage plus a circular array,
// with occupancy count, almost-full/almost-empty flags, synchronous flush and optional empty bypass.
module falafel_stream_fifo #(
    parameter int DEPTH     = 64,
    parameter int DATA_W    = 16,
    parameter int AF_THRESH = 60,
    parameter int AE_THRESH = 4,
    parameter int BYPASS_EN = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [DATA_W-1:0]          in_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [DATA_W-1:0]          out_data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       almost_full_o,
    output logic                       almost_empty_o
);

    localparam int CNT_W     = $clog2(DEPTH + 1);
    localparam int ARR_DEPTH = DEPTH - 1;
    localparam int PTR_W     = (ARR_DEPTH > 1) ? $clog2(ARR_DEPTH) : 1;

    if (DEPTH < 2) begin : gBadDepth
        $error("falafel_stream_fifo: DEPTH must be at least 2");
    end
    if (AF_THRESH < 0 || AF_THRESH > DEPTH) begin : gBadAf
        $error("falafel_stream_fifo: AF_THRESH must lie within 0..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH) begin : gBadAe
        $error("falafel_stream_fifo: AE_THRESH must lie within 0..DEPTH");
    end

    logic [DATA_W-1:0] mem_q [ARR_DEPTH];

    logic [DATA_W-1:0] headData_q, headData_d;
    logic              headValid_q, headValid_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  arrCount_q, arrCount_d;
    logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;

    logic push, pop, headFree, loadFromArr, loadBypass, arrWrite;

    // Array pointers wrap explicitly so non-power-of-2 depths work.
    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(ARR_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign in_ready_o     = (count_q < CNT_W'(DEPTH));
    assign out_valid_o    = headValid_q;
    assign out_data_o     = headData_q;
    assign count_o        = count_q;
    assign almost_full_o  = (count_q >= CNT_W'(AF_THRESH));
    assign almost_empty_o = (count_q <= CNT_W'(AE_THRESH));

    // The head refills from the array first; a new word only bypasses into it when the array is empty.
    always_comb begin
        push        = in_valid_i && in_ready_o;
        pop         = headValid_q && out_ready_i;
        headFree    = !headValid_q || pop;
        loadFromArr = headFree && (arrCount_q != '0);
        loadBypass  = (BYPASS_EN != 0) && headFree && (arrCount_q == '0) && push;
        arrWrite    = push && !loadBypass;

        headData_d  = headData_q;
        headValid_d = headValid_q;
        rdPtr_d     = rdPtr_q;
        wrPtr_d     = wrPtr_q;

        if (loadFromArr) begin
            headData_d  = mem_q[rdPtr_q];
            headValid_d = 1'b1;
            rdPtr_d     = nextPtr(rdPtr_q);
        end else if (loadBypass) begin
            headData_d  = in_data_i;
            headValid_d = 1'b1;
        end else if (headFree) begin
            headValid_d = 1'b0;
        end

        if (arrWrite) begin
            wrPtr_d = nextPtr(wrPtr_q);
        end

        arrCount_d = arrCount_q + CNT_W'(arrWrite) - CNT_W'(loadFromArr);
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);

        // Flush discards everything in flight but keeps the last head data visible.
        if (flush_i) begin
            headData_d  = headData_q;
            headValid_d = 1'b0;
            rdPtr_d     = '0;
            wrPtr_d     = '0;
            arrCount_d  = '0;
            count_d     = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            headData_q  <= '0;
            headValid_q <= 1'b0;
            count_q     <= '0;
            arrCount_q  <= '0;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
        end else begin
            headData_q  <= headData_d;
            headValid_q <= headValid_d;
            count_q     <= count_d;
            arrCount_q  <= arrCount_d;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && !flush_i && arrWrite) begin
            mem_q[wrPtr_q] <= in_data_i;
        end
    end

endmodule
